// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of a 5-stage ARM pipeline. Holds the program
//   counter, presents it to a combinational instruction memory, and captures
//   the returned word plus its PC+4 into the IF/ID pipeline register.
//   A branch redirect from execute overrides a hazard freeze and flushes IF/ID.
//
// Optional build macro: FETCH_STAT_EN (adds fetch/stall/flush counters).
//
// Ports:
//   clk           in   pipeline clock, rising edge
//   rst           in   synchronous active-high reset
//   freeze        in   hazard stall: hold PC and IF/ID
//   branch_taken  in   redirect PC and flush IF/ID
//   branch_addr   in   redirect target byte address (low 2 bits ignored)
//   imem_addr     out  byte address to instruction memory (= PC)
//   imem_inst     in   instruction returned for imem_addr
//   ifid_pc       out  PC+4 of the instruction in IF/ID
//   ifid_inst     out  instruction in IF/ID
//   ifid_valid    out  IF/ID holds a real fetched instruction
//   stat_fetched  out  (FETCH_STAT_EN) count of valid IF/ID loads
//   stat_stalls   out  (FETCH_STAT_EN) count of freeze-only edges
//   stat_flushes  out  (FETCH_STAT_EN) count of branch edges
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000,
  parameter logic [INST_W-1:0]  NOP_INST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [INST_W-1:0] ifid_inst,
  output logic              ifid_valid
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_stalls,
  output logic [15:0]       stat_flushes
`endif
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ifid_pc;
  logic [INST_W-1:0] r_ifid_inst;
  logic              r_ifid_valid;

  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_branch_target;

  // Natural wrap at 2^ADDR_W is intended.
  assign w_pc_plus4      = r_pc + ADDR_W'(4);
  // Misaligned targets are silently word-aligned.
  assign w_branch_target = {branch_addr[ADDR_W-1:2], 2'b00};

  assign imem_addr  = r_pc;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_inst  = r_ifid_inst;
  assign ifid_valid = r_ifid_valid;

  // Program counter. branch_addr is only looked at when branch_taken is set,
  // so an undriven target cannot leak into the PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (branch_taken) begin
      r_pc <= w_branch_target;
    end else if (!freeze) begin
      r_pc <= w_pc_plus4;
    end
  end

  // IF/ID register. A redirect flushes even while frozen: the instruction
  // being held belongs to the wrong path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid_pc    <= '0;
      r_ifid_inst  <= NOP_INST;
      r_ifid_valid <= 1'b0;
    end else if (branch_taken) begin
      r_ifid_pc    <= '0;
      r_ifid_inst  <= NOP_INST;
      r_ifid_valid <= 1'b0;
    end else if (!freeze) begin
      r_ifid_pc    <= w_pc_plus4;
      r_ifid_inst  <= imem_inst;
      r_ifid_valid <= 1'b1;
    end
  end

`ifdef FETCH_STAT_EN
  logic [31:0] r_stat_fetched;
  logic [31:0] r_stat_stalls;
  logic [15:0] r_stat_flushes;

  assign stat_fetched = r_stat_fetched;
  assign stat_stalls  = r_stat_stalls;
  assign stat_flushes = r_stat_flushes;

  // Counters wrap silently at their maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_fetched <= '0;
      r_stat_stalls  <= '0;
      r_stat_flushes <= '0;
    end else if (branch_taken) begin
      r_stat_flushes <= r_stat_flushes + 16'd1;
    end else if (freeze) begin
      r_stat_stalls  <= r_stat_stalls + 32'd1;
    end else begin
      r_stat_fetched <= r_stat_fetched + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage ARM pipeline.
- Owns the program counter and drives the word address into the combinational instruction memory.
- Captures the returned instruction and its PC+4 into the IF/ID pipeline register for the decode stage.
- Handles hazard freeze from the hazard unit, and branch redirect/flush from the execute stage.

Parameters:
- ADDR_W, 32, width of PC and instruction address.
- INST_W, 32, instruction word width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INST, 32'h0000_0000, instruction value inserted into IF/ID on a bubble.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hazard-unit stall; holds PC and IF/ID.
- branch_taken  in  1  execute-stage redirect; also flushes IF/ID.
- branch_addr  in  ADDR_W  redirect target byte address.
- imem_addr  out  ADDR_W  byte address to instruction memory; equals current PC.
- imem_inst  in  INST_W  combinational instruction returned for imem_addr.
- ifid_pc  out  ADDR_W  registered PC+4 of the fetched instruction.
- ifid_inst  out  INST_W  registered instruction.
- ifid_valid  out  1  registered; 1 when ifid_inst is a real fetched instruction.

Behaviour:
- Reset values:
  - PC = RESET_PC
  - ifid_pc = 0
  - ifid_inst = NOP_INST
  - ifid_valid = 0
- rst is sampled only at the clock edge. rst asserted mid-operation discards any redirect or freeze in that cycle; the next cycle fetches from RESET_PC.
- imem_addr = PC, combinational from the PC register; no other logic in the path.
- Next-PC priority per edge, rst highest:
  - rst: RESET_PC.
  - else branch_taken: {branch_addr[ADDR_W-1:2], 2'b00}. Low two bits are forced to zero; misaligned targets are silently aligned.
  - else freeze: PC unchanged.
  - else: PC + 4, modulo 2^ADDR_W. 0xFFFF_FFFC wraps to 0x0000_0000.
- IF/ID register priority per edge:
  - rst: reset values.
  - else branch_taken (flush): ifid_inst = NOP_INST, ifid_pc = 0, ifid_valid = 0. Applies even if freeze = 1.
  - else freeze: all three outputs hold their value.
  - else: ifid_inst = imem_inst, ifid_pc = PC + 4 (same wrap rule), ifid_valid = 1.
- Latency:
  - The instruction at PC appears on ifid_inst one edge after PC is presented, with freeze = 0 and branch_taken = 0.
  - The first valid instruction after reset release appears on the second edge.
  - Redirect: the target is presented on imem_addr the cycle after branch_taken and enters IF/ID one edge later. Exactly one bubble is produced by this stage.
- Simultaneous branch_taken and freeze: the branch wins for both PC and IF/ID.
- Inputs branch_addr and imem_inst are don't-care when not selected. X on them must not propagate into PC or IF/ID unless selected.
- No internal state machine beyond PC and IF/ID. Throughput is one instruction per cycle when not frozen.

Optional Feature:
- Macro: FETCH_STAT_EN.
- Defined:
  - Adds output stat_fetched (32 bits): increments on every edge that loads a valid instruction into IF/ID.
  - Adds output stat_stalls (32 bits): increments on every edge with freeze = 1 and branch_taken = 0.
  - Adds output stat_flushes (16 bits): increments on every edge with branch_taken = 1.
  - All three reset to 0 on rst and wrap silently at their maximum.
- Not defined:
  - Ports and counters are absent.
  - Remaining behaviour is identical.

Test Plan:
- Reset then run 4 cycles with memory words 0xE3A0_0A01, 0xE3A0_1015, 0xE3A0_2018 at byte addresses 0, 4, 8 → imem_addr sequence 0, 4, 8, 12. ifid_valid goes 0, 1, 1, 1. ifid_inst/ifid_pc = 0xE3A0_0A01/4, then 0xE3A0_1015/8, then 0xE3A0_2018/12.
- freeze = 1 for 2 cycles while PC = 8 → imem_addr stays 8 and IF/ID holds the PC = 4 entry (ifid_pc = 8). After release, PC advances to 12 and ifid_pc = 12.
- branch_taken = 1 with branch_addr = 0x14 at PC = 0x10 → next imem_addr = 0x14. ifid_valid = 0 and ifid_inst = NOP_INST for one cycle, then the instruction at 0x14 arrives with ifid_pc = 0x18.
- branch_taken = 1 and freeze = 1 in the same cycle, branch_addr = 0x23 → PC = 0x20 (aligned) and IF/ID flushed.
- RESET_PC = 32'hFFFF_FFF8, run 3 cycles → imem_addr 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. The ifid_pc for the 0xFFFF_FFFC fetch is 0x0000_0000.
- With FETCH_STAT_EN defined: 5 normal cycles, 2 freeze cycles, 1 branch → stat_fetched = 5, stat_stalls = 2, stat_flushes = 1. rst mid-run clears all three to 0.
